sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO: the same-clock successor to the dual-clock FIFO. It adds a selectable first-word-fall-through (FWFT) output mode, programmable almost-full/almost-empty thresholds, a live occupancy count, and overflow/underflow error pulses. It is used as the general-purpose buffer between pipeline stages that share one clock domain, with no Gray-code synchroniser chain.

## Interface
- `DATA_WIDTH`, 8: word width.
- `DEPTH`, 16: capacity in words; power of two, ≥4.
- `ADDR_WIDTH`, $clog2(DEPTH): RAM address width.
- `FWFT`, 0: 0 = standard (registered read); 1 = first-word-fall-through.
- `AF_LEVEL`, DEPTH-2: almost-full threshold, 1..DEPTH.
- `AE_LEVEL`, 2: almost-empty threshold, 0..DEPTH-1.
- One clock; reset is synchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `wr_en` in 1: write request.
- `wr_din` in DATA_WIDTH: write data.
- `fifo_full` out 1: level == DEPTH.
- `fifo_almost_full` out 1: level ≥ AF_LEVEL.
- `rd_en` in 1: read request (standard mode) or acknowledge (FWFT).
- `rd_dout` out DATA_WIDTH: read data.
- `rd_valid` out 1: rd_dout holds valid data.
- `fifo_empty` out 1: no word readable.
- `fifo_almost_empty` out 1: level ≤ AE_LEVEL.
- `fifo_level` out ADDR_WIDTH+1: words held, 0..DEPTH.
- `overflow` out 1: one-cycle pulse on a refused write.
- `underflow` out 1: one-cycle pulse on a refused read.

## Operation
- **Write acceptance:** `wr_acc = wr_en & ~fifo_full`. The word goes to RAM at the write pointer; the pointer increments and wraps modulo DEPTH.
- **Read acceptance:** `rd_acc = rd_en & ~fifo_empty`.
- **Level:** `level_next = level + wr_acc - rd_acc`, computed in ADDR_WIDTH+1 bits; it never wraps.
- **Flags:** all flags and `fifo_level` are registered from `level_next`, so each reflects the state after the current edge.
- **Full:** `wr_en` with `rd_en` while full: the write is refused and the read is accepted; level drops by 1, `overflow` pulses.
- **Empty:** `wr_en` with `rd_en` while empty: the read is refused and the write is accepted; level becomes 1, `underflow` pulses.
- **Standard mode (FWFT=0):**
  - An accepted read registers the RAM word into `rd_dout`.
  - `rd_valid` pulses high for exactly the cycle after `rd_acc`.
  - `rd_dout` holds its last value otherwise.
  - `fifo_empty = (level == 0)`.
- **FWFT mode (FWFT=1):**
  - An output stage holds the head word; `rd_valid` = stage full, and `fifo_empty = ~rd_valid`.
  - When the stage is empty or being acknowledged (`rd_acc`) and RAM holds a word, the stage refills from RAM.
  - `fifo_level` counts RAM words plus the stage word; total capacity stays DEPTH.
  - `rd_en` while `rd_valid` = 0 is refused and pulses `underflow`.
- **Error pulses:** `overflow` and `underflow` are registered, high one cycle after the offending request. They are not sticky.
- **Reset:**
  - Pointers, level, `rd_dout`, `rd_valid`, `fifo_full`, `fifo_almost_full`, `overflow` and `underflow` all go to 0.
  - `fifo_empty` = 1 and `fifo_almost_empty` = 1.
  - Reset asserted mid-burst discards all contents; requests in the reset cycle are ignored.

## Timing
- **Write → flags:** a write accepted at edge N updates `fifo_level`, `fifo_empty` and the almost flags after edge N.
- **Standard read:** `rd_en` sampled at edge M (not empty) → `rd_dout`/`rd_valid` valid after edge M. Latency is 1 cycle.
- **Back-to-back:** reads sustain one word per cycle; `rd_valid` stays high continuously.
- **FWFT, empty FIFO:** write at edge N → head word on `rd_dout` with `rd_valid` = 1 after edge N+1.
- **FWFT, acknowledge:** `rd_en` at edge M with ≥2 words held → the next word appears after edge M with no bubble.
- **Full recovery:** a read at edge M clears `fifo_full` after edge M; a write is accepted at edge M+1.
- **RAM:** no read-during-write same-address hazard exists, because a word is never read in the cycle it is written. In FWFT the refill trails the write by one edge.

## Structure
- **Shared `config.v`:** holds mode constants `FIFO_MODE_STD` = 0 and `FIFO_MODE_FWFT` = 1, plus the default threshold macros.
- **Storage:** `async_tpram` instantiated with `wr_clk` and `rd_clk` both tied to `clk`; no new RAM model.
- **Sub-module `sync_fifo_fwft_stage`:** the output stage (head register, valid, refill control). It is instantiated only under `FWFT`; standard mode uses the plain `rd_dout` register.
- **Flag and error registers:** `gnrl_dffr`-style, written as synchronous-reset flops.

## Test plan
- **Fill/drain:** DEPTH=16, FWFT=0, write 0x00..0x0F → `fifo_full`=1, level=16, `fifo_almost_full` from level 14. 17th write → `overflow` pulse, data unchanged. Drain → 0x00..0x0F in order, `fifo_empty`=1 at end.
- **Simultaneous at boundaries:** full + `wr_en` + `rd_en` → level 15, `overflow` pulse. Empty + both → level 1, `underflow` pulse, `rd_valid` stays 0.
- **Wrap-around:** 40 random words, interleaved writes and reads holding level between 3 and 12 → output matches scoreboard; `fifo_level` exact every cycle.
- **FWFT:** FWFT=1, write 0xA5 at edge N → `rd_dout`=0xA5, `rd_valid`=1 after edge N+1. Write 3 more, hold `rd_en` high → 4 words on 4 consecutive cycles, no bubble.
- **Thresholds:** AF_LEVEL=12, AE_LEVEL=4 → almost flags toggle exactly at level 12 and level 4 crossings, both directions.
- **Reset mid-operation:** `rst` pulsed at level 9 → next cycle: level 0, `fifo_empty`=1, `rd_valid`=0, `rd_dout`=0. A subsequent write/read returns the new data, not stale contents.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and flag bundle for the single-clock FIFO.
// Mode selectors and reset values used by the FIFO top level.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  localparam int FIFO_AE_DEFAULT = 2;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RST = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/sync_fifo_fwft_stage.sv
// First-word-fall-through output stage: head register plus valid bit.
// Loaded from RAM when empty or when the head is being acknowledged.
module sync_fifo_fwft_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;

  always_comb begin
    dout_d  = load ? din : dout_q;
    valid_d = load | (valid_q & ~ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or FWFT output, programmable
// almost flags, occupancy count and overflow/underflow pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = FIFO_AE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_din,
  output logic                  fifo_full,
  output logic                  fifo_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_valid,
  output logic                  fifo_empty,
  output logic                  fifo_almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_LEVEL);
  localparam bit IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [LW-1:0]         ram_cnt_q, ram_cnt_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  wr_acc, rd_acc, ram_pop;
  logic                  stage_valid, stage_valid_nx;

  // ram_cnt tracks words still in RAM; in FWFT the head word lives in the stage
  always_comb begin
    wr_acc   = wr_en & ~flags_q.full;
    rd_acc   = rd_en & ~flags_q.empty;
    ram_pop  = IS_FWFT ? ((~stage_valid | rd_acc) & (ram_cnt_q != '0))
                       : rd_acc;
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(ram_pop);
    level_d  = level_q + LW'(wr_acc) - LW'(rd_acc);
    ram_cnt_d = ram_cnt_q + LW'(wr_acc) - LW'(ram_pop);
    stage_valid_nx = ram_pop | (stage_valid & ~rd_acc);
    flags_d = FLAGS_RST;
    flags_d.full         = (level_d == LVL_FULL);
    flags_d.almost_full  = (level_d >= LVL_AF);
    flags_d.empty        = IS_FWFT ? ~stage_valid_nx : (level_d == '0);
    flags_d.almost_empty = (level_d <= LVL_AE);
    flags_d.overflow     = wr_en & flags_q.full;
    flags_d.underflow    = rd_en & flags_q.empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ram_cnt_q <= '0;
      flags_q   <= FLAGS_RST;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ram_cnt_q <= ram_cnt_d;
      flags_q   <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_din;
  end

  assign ram_rd = mem[rd_ptr_q];

  if (IS_FWFT) begin : g_fwft
    sync_fifo_fwft_stage #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .load  (ram_pop),
      .ack   (rd_acc),
      .din   (ram_rd),
      .dout  (rd_dout),
      .valid (stage_valid)
    );
    assign rd_valid = stage_valid;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    always_comb begin
      dout_d  = rd_acc ? ram_rd : dout_q;
      valid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign rd_dout     = dout_q;
    assign rd_valid    = valid_q;
    assign stage_valid = 1'b0;
  end

  assign fifo_full         = flags_q.full;
  assign fifo_almost_full  = flags_q.almost_full;
  assign fifo_empty        = flags_q.empty;
  assign fifo_almost_empty = flags_q.almost_empty;
  assign fifo_level        = level_q;
  assign overflow          = flags_q.overflow;
  assign underflow         = flags_q.underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: standard, FWFT and custom-threshold instances
// driven by one shared stimulus stream.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_din;
  logic       rd_en;

  logic       s_full, s_af, s_empty, s_ae, s_valid, s_ovf, s_unf;
  logic [7:0] s_dout;
  logic [4:0] s_level;

  logic       f_full, f_af, f_empty, f_ae, f_valid, f_ovf, f_unf;
  logic [7:0] f_dout;
  logic [4:0] f_level;

  logic       t_full, t_af, t_empty, t_ae, t_valid, t_ovf, t_unf;
  logic [7:0] t_dout;
  logic [4:0] t_level;

  int checks = 0;
  int errors = 0;

  sync_fifo u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din),
    .fifo_full(s_full), .fifo_almost_full(s_af),
    .rd_en(rd_en), .rd_dout(s_dout), .rd_valid(s_valid),
    .fifo_empty(s_empty), .fifo_almost_empty(s_ae),
    .fifo_level(s_level), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din),
    .fifo_full(f_full), .fifo_almost_full(f_af),
    .rd_en(rd_en), .rd_dout(f_dout), .rd_valid(f_valid),
    .fifo_empty(f_empty), .fifo_almost_empty(f_ae),
    .fifo_level(f_level), .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo #(.AF_LEVEL(12), .AE_LEVEL(4)) u_thr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_din(wr_din),
    .fifo_full(t_full), .fifo_almost_full(t_af),
    .rd_en(rd_en), .rd_dout(t_dout), .rd_valid(t_valid),
    .fifo_empty(t_empty), .fifo_almost_empty(t_ae),
    .fifo_level(t_level), .overflow(t_ovf), .underflow(t_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d,
                     input logic r);
    wr_en  = w;
    wr_din = d;
    rd_en  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       w, r;
    logic [7:0] d;
    int         wrote;
    int         guard;

    rst = 1'b1;
    wr_en = 1'b0;
    wr_din = 8'h00;
    rd_en = 1'b0;
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b1, 8'h78, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);

    chk("rst_level", s_level, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_ae", s_ae, 1);
    chk("rst_full", s_full, 0);
    chk("rst_af", s_af, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_dout", s_dout, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_unf", s_unf, 0);
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_valid", f_valid, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk($sformatf("fill_lvl%0d", i), s_level, i + 1);
      chk($sformatf("fill_af%0d", i), s_af, (i + 1 >= 14));
      chk($sformatf("fill_full%0d", i), s_full, (i + 1 == 16));
      chk($sformatf("fill_empty%0d", i), s_empty, 0);
      chk($sformatf("fill_ae%0d", i), s_ae, (i + 1 <= 2));
      chk($sformatf("thr_af_up%0d", i), t_af, (i + 1 >= 12));
      chk($sformatf("thr_ae_up%0d", i), t_ae, (i + 1 <= 4));
    end

    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf_pulse", s_ovf, 1);
    chk("ovf_level", s_level, 16);
    chk("ovf_full", s_full, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", s_ovf, 0);

    cyc(1'b1, 8'hDD, 1'b1);
    chk("both_full_lvl", s_level, 15);
    chk("both_full_ovf", s_ovf, 1);
    chk("both_full_valid", s_valid, 1);
    chk("both_full_dout", s_dout, 8'h00);
    chk("both_full_full", s_full, 0);

    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain_dout%0d", i), s_dout, i);
      chk($sformatf("drain_valid%0d", i), s_valid, 1);
      chk($sformatf("drain_lvl%0d", i), s_level, 15 - i);
      chk($sformatf("thr_af_dn%0d", i), t_af, (15 - i >= 12));
      chk($sformatf("thr_ae_dn%0d", i), t_ae, (15 - i <= 4));
    end
    chk("drain_empty", s_empty, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_valid", s_valid, 0);
    chk("idle_hold", s_dout, 8'h0F);

    cyc(1'b1, 8'h5A, 1'b1);
    chk("both_empty_lvl", s_level, 1);
    chk("both_empty_unf", s_unf, 1);
    chk("both_empty_valid", s_valid, 0);
    chk("both_empty_empty", s_empty, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("both_empty_dout", s_dout, 8'h5A);
    chk("both_empty_rdv", s_valid, 1);
    chk("both_empty_lvl0", s_level, 0);
    chk("unf_clear", s_unf, 0);

    wrote = 0;
    guard = 0;
    while ((wrote < 40 || q.size() > 0) && guard < 1000) begin
      guard++;
      if (wrote < 40) begin
        w = (q.size() < 3) ||
            (q.size() < 12 && $urandom_range(0, 1) == 1);
        r = (q.size() > 3) && ($urandom_range(0, 1) == 1);
      end else begin
        w = 1'b0;
        r = 1'b1;
      end
      d = 8'($urandom_range(0, 255));
      cyc(w, d, r);
      exp_d = 8'h00;
      if (r) exp_d = q.pop_front();
      if (w) begin
        q.push_back(d);
        wrote++;
      end
      chk("wrap_lvl", s_level, q.size());
      chk("wrap_valid", s_valid, r);
      if (r) chk("wrap_dout", s_dout, exp_d);
    end
    chk("wrap_guard", guard < 1000, 1);

    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pre_rst_lvl", s_level, 9);
    chk("pre_rst_dout", s_dout, 8'h90);
    rst = 1'b1;
    cyc(1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    chk("mid_rst_lvl", s_level, 0);
    chk("mid_rst_empty", s_empty, 1);
    chk("mid_rst_valid", s_valid, 0);
    chk("mid_rst_dout", s_dout, 0);
    cyc(1'b1, 8'h3C, 1'b0);
    chk("post_rst_lvl", s_level, 1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_dout", s_dout, 8'h3C);
    chk("post_rst_valid", s_valid, 1);

    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("fw_rst_lvl", f_level, 0);
    chk("fw_rst_empty", f_empty, 1);

    cyc(1'b1, 8'hA5, 1'b0);
    chk("fw_n_valid", f_valid, 0);
    chk("fw_n_lvl", f_level, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fw_n1_valid", f_valid, 1);
    chk("fw_n1_dout", f_dout, 8'hA5);
    chk("fw_n1_empty", f_empty, 0);
    cyc(1'b1, 8'hB1, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0);
    chk("fw_lvl4", f_level, 4);
    chk("fw_head", f_dout, 8'hA5);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk($sformatf("fw_burst_dout%0d", i), f_dout, 8'hB0 + i);
      chk($sformatf("fw_burst_valid%0d", i), f_valid, 1);
      chk($sformatf("fw_burst_lvl%0d", i), f_level, 4 - i);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("fw_end_valid", f_valid, 0);
    chk("fw_end_empty", f_empty, 1);
    chk("fw_end_lvl", f_level, 0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fw_unf", f_unf, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fw_unf_clear", f_unf, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
